cla_nibble_seq_adder: RTL
=========================

// Module: cla_nibble_seq_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder controller. Time-shares one 4-bit carry-look-ahead slice
//   across WIDTH/4 cycles, one nibble per cycle, LSB nibble first.
//   Inter-nibble carry is registered between cycles.
//   Sits between an operand producer and a result consumer, with valid/ready on both sides.
// PARAMETERS
//   WIDTH  16  operand/sum width; multiple of 4, >= 4. NIB = WIDTH/4 = cycles per add.
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active-low
//   in_valid   in   1      operand request
//   in_ready   out  1      controller can accept operands
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in to nibble 0
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes result
//   out_sum    out  WIDTH  sum (A+B+cin) mod 2^WIDTH
//   out_cout   out  1      carry out of MSB nibble
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at edge):
//     - state=IDLE, idx=0, carry=0, out_sum=0, out_cout=0, out_valid=0, busy=0.
//     - Reset overrides everything, incl. mid-RUN/DONE: operation aborted, no result emitted.
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE:
//     - in_ready=1.
//     - in_valid&&in_ready at edge: latch a_q=in_a, b_q=in_b, carry=in_cin, idx=0 -> RUN.
//   RUN:
//     - in_ready=0; in_valid ignored; latched operands immune to input changes.
//     - Each edge: slice adds a_q[4*idx+:4] + b_q[4*idx+:4] + carry.
//       Sum nibble -> sum_q[4*idx+:4]; slice cout -> carry; idx++.
//     - On edge where idx==NIB-1: out_cout<=slice cout -> DONE.
//   DONE:
//     - out_valid=1; out_sum/out_cout held stable until out_valid&&out_ready at edge -> IDLE.
//     - in_ready=0 in DONE (no accept on the handoff cycle).
//   Latency: out_valid rises NIB cycles after the accepting edge (WIDTH=16: 4).
//   Throughput: one op per NIB+2 cycles with in_valid and out_ready held high.
//   Width rules:
//     - Sum truncated to WIDTH; overflow reported only via out_cout.
//     - idx is $clog2(NIB) bits (min 1); never wraps past NIB-1.
//   NIB=1 (WIDTH=4): RUN lasts exactly one cycle.
//   out_sum outside DONE is don't-care to the consumer, but must not be X after reset.
// STRUCTURE
//   Package cla_seq_pkg:
//     - localparam NIBBLE_W=4.
//     - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} cla_seq_state_t.
//   Sub-module cla4_slice (a[3:0], b[3:0], cin -> s[3:0], cout):
//     - P=a^b, G=a&b, carries c1..c4 fully look-ahead, s=P^{c3,c2,c1,cin}.
//     - Purely combinational; single instance.
//   Top holds: FSM, idx counter, carry reg, operand regs, result regs.
// TESTING (WIDTH=16 unless noted)
//   1 A=0x0001 B=0x0002 cin=0 -> sum=0x0003 cout=0; out_valid exactly 4 cycles after accept.
//   2 A=0xFFFF B=0x0001 cin=0 -> sum=0x0000 cout=1 (carry crosses all nibble boundaries).
//   3 A=0x8000 B=0x8000 cin=1 -> sum=0x0001 cout=1; inputs changed after accept do not alter result.
//   4 Hold out_ready=0 for 5 cycles in DONE, drive in_valid=1:
//     -> out_valid/out_sum stable, in_ready=0, no accept.
//     -> out_ready=1: IDLE next cycle, then new op accepted.
//   5 rst_n=0 for one edge after 2 RUN cycles -> next cycle state IDLE, out_valid=0, in_ready=1, busy=0.
//     -> No stale result ever appears.
//   6 1000 random ops, WIDTH=16 and WIDTH=4, in_valid/out_ready held 1:
//     -> every {cout,sum} == A+B+cin.
//     -> accept-to-accept spacing == NIB+2 cycles.

Source files
------------

// File: rtl/cla_nibble_seq_adder_pkg.sv
// Shared types and constants for the nibble-serial carry-look-ahead adder.
// The controller walks the operands one 4-bit nibble at a time.
package cla_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } cla_seq_state_t;

endpackage : cla_seq_pkg

// File: rtl/cla_nibble_seq_adder_slice.sv
// 4-bit carry-look-ahead slice: every carry is computed directly from
// propagate/generate terms, so no ripple path runs through the slice.
module cla4_slice
    import cla_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] g;
    logic                c1;
    logic                c2;
    logic                c3;

    assign p = a ^ b;
    assign g = a & b;

    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

endmodule : cla4_slice

// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle adder: one shared CLA slice processes a nibble per cycle, LSB first,
// with the inter-nibble carry held in a register. Valid/ready on both sides.
//
// state  | meaning
// S_IDLE | ready for operands; accept latches a, b, cin
// S_RUN  | one nibble per cycle, idx counts 0..NIB-1
// S_DONE | result presented on out_sum/out_cout until consumer takes it
module cla_nibble_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    cla_seq_state_t      state_q;
    cla_seq_state_t      state_d;
    logic [IDX_W-1:0]    idx_q;
    logic                carry_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    sum_q;
    logic                cout_q;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_cout;
    logic                last_nib;

    assign last_nib = (idx_q == IDX_LAST);

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    cla4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RUN;
            S_RUN:   if (last_nib) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    // idx holds at NIB-1 after the last nibble; the next accept clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
                        idx_q   <= '0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            sum_q[i*NIBBLE_W +: NIBBLE_W] <= slice_s;
                        end
                    end
                    carry_q <= slice_cout;
                    if (last_nib) begin
                        cout_q <= slice_cout;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule : cla_nibble_seq_adder
